timer_count_core: RTL and testbench

- Counting engine of the programmable timer.
- Owns the down-counter, reload register, prescaler, run state machine, interrupt pulse and PWM output.
- Drives current_count to the timer's mode/compare decoder.
- Consumes that decoder's combinational event flags (one_shot, periodic, pwm_match, off_signal) to decide stop, reload and PWM edges.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_count_core_prescaler.sv | 29 ++
 rtl/timer_count_core.sv | 129 ++++++++++++
 tb/tb_timer_count_core.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types for the programmable timer: mode encoding, run states
// and default widths.
package timer_pkg;

    localparam int CNT_W_DEF   = 32;
    localparam int PRESC_W_DEF = 8;

    typedef enum logic [1:0] {
        OFF      = 2'b00,
        ONE_SHOT = 2'b01,
        PERIODIC = 2'b10,
        PWM      = 2'b11
    } timer_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tmr_state_e;

    function automatic logic is_pwm(input logic [1:0] m);
        return timer_mode_e'(m) == PWM;
    endfunction

endpackage

// File: rtl/timer_count_core_prescaler.sv
// Clock divider for the timer: one tick every prescale+1 clocks while
// not held in clear.
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);

    logic [PRESC_W-1:0] presc_cnt;

    assign tick = !clear && (presc_cnt == prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (clear || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/timer_count_core.sv
// Counting engine of the programmable timer: down-counter, reload,
// run state machine, expiry pulse and PWM waveform.
module timer_count_core
    import timer_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [CNT_W-1:0]   load_value,
    input  logic               load_strobe,
    input  logic               one_shot,
    input  logic               periodic,
    input  logic               pwm_match,
    input  logic               off_signal,
    output logic [CNT_W-1:0]   current_count,
    output logic               irq,
    output logic               pwm_out,
    output logic               running,
    output logic               done
);

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             pwm_q, pwm_d;
    logic             irq_q, irq_d;
    logic             tick;
    logic             stop_req;
    logic             count_zero;

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (!running),
        .prescale (prescale),
        .tick     (tick)
    );

    assign stop_req   = !enable || off_signal;
    assign count_zero = (count_q == '0);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pwm_d    = pwm_q;
        irq_d    = 1'b0;
        if (load_strobe) begin
            reload_d = load_value;
        end
        unique case (state_q)
            IDLE: begin
                if (load_strobe) begin
                    count_d = load_value;
                end
                if (!stop_req) begin
                    state_d = RUN;
                    count_d = reload_q;
                    pwm_d   = is_pwm(mode);
                end
            end
            RUN: begin
                // Stop is honoured every clock; events only on ticks.
                if (stop_req) begin
                    state_d = IDLE;
                    pwm_d   = 1'b0;
                end else if (tick) begin
                    if (one_shot) begin
                        state_d = DONE;
                        irq_d   = 1'b1;
                    end else if (periodic) begin
                        count_d = reload_q;
                        irq_d   = 1'b1;
                    end else if (is_pwm(mode) && count_zero) begin
                        count_d = reload_q;
                        pwm_d   = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        if (pwm_match) begin
                            pwm_d = 1'b0;
                        end
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (load_strobe) begin
                    count_d = load_value;
                end
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pwm_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pwm_q    <= pwm_d;
            irq_q    <= irq_d;
        end
    end

    assign current_count = count_q;
    assign irq           = irq_q;
    assign pwm_out       = pwm_q;
    assign running       = (state_q == RUN);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_timer_count_core.sv
// Scenario bench for timer_count_core with a behavioural mode/compare
// decoder and a queue of expected per-clock outputs.
module tb_timer_count_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  prescale;
    logic [31:0] load_value;
    logic        load_strobe;
    logic [31:0] compare_value;
    logic        one_shot, periodic, pwm_match, off_signal;
    logic [31:0] current_count;
    logic        irq, pwm_out, running, done;

    typedef struct {
        logic [31:0] cnt;
        logic        irq;
        logic        pwm;
        logic        run;
        logic        dn;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    assign one_shot   = (mode == 2'b01) && (current_count == 32'd0);
    assign periodic   = (mode == 2'b10) && (current_count == 32'd0);
    assign pwm_match  = (mode == 2'b11) && (current_count == compare_value);
    assign off_signal = (mode == 2'b00);

    timer_count_core dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .mode          (mode),
        .prescale      (prescale),
        .load_value    (load_value),
        .load_strobe   (load_strobe),
        .one_shot      (one_shot),
        .periodic      (periodic),
        .pwm_match     (pwm_match),
        .off_signal    (off_signal),
        .current_count (current_count),
        .irq           (irq),
        .pwm_out       (pwm_out),
        .running       (running),
        .done          (done)
    );

    function automatic exp_t mk(input int c, input bit i, input bit p,
                                input bit r, input bit d);
        exp_t x;
        x.cnt = c;
        x.irq = i;
        x.pwm = p;
        x.run = r;
        x.dn  = d;
        return x;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 0; mode = 0; prescale = 0;
        load_value = 0; load_strobe = 0; compare_value = 0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({current_count, irq, pwm_out, running, done} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset got cnt=%0d irq=%b pwm=%b run=%b done=%b want all 0",
                     current_count, irq, pwm_out, running, done);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({current_count, irq, pwm_out, running, done} !== 36'd0) begin
            miscompares++;
            $display("FAIL reset_release got cnt=%0d irq=%b pwm=%b run=%b done=%b want all 0",
                     current_count, irq, pwm_out, running, done);
        end
    endtask

    task automatic test_one_shot();
        mode = 2'b01; prescale = 0; load_value = 5;
        q.push_back(mk(5, 0, 0, 0, 0));
        q.push_back(mk(5, 0, 0, 1, 0));
        for (int i = 1; i <= 5; i++) q.push_back(mk(5 - i, 0, 0, 1, 0));
        q.push_back(mk(0, 1, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            load_strobe = (c == 0);
            enable = (c >= 1 && c <= 9);
            @(posedge clk);
            #1;
            e = q.pop_front();
            vectors++;
            if ({current_count, irq, pwm_out, running, done} !==
                {e.cnt, e.irq, e.pwm, e.run, e.dn}) begin
                miscompares++;
                $display("FAIL one_shot c=%0d got cnt=%0d irq=%b pwm=%b run=%b done=%b want cnt=%0d irq=%b pwm=%b run=%b done=%b",
                         c, current_count, irq, pwm_out, running, done,
                         e.cnt, e.irq, e.pwm, e.run, e.dn);
            end
        end
    endtask

    task automatic test_periodic_prescale();
        int t;
        mode = 2'b10; prescale = 3; load_value = 2;
        q.push_back(mk(2, 0, 0, 0, 0));
        for (int j = 0; j <= 36; j++) begin
            t = j / 4;
            q.push_back(mk(2 - (t % 3), (j % 4 == 0) && t > 0 && (t % 3 == 0), 0, 1, 0));
        end
        q.push_back(mk(2, 0, 0, 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            load_strobe = (c == 0);
            enable = (c >= 1 && c <= 37);
            @(posedge clk);
            #1;
            e = q.pop_front();
            vectors++;
            if ({current_count, irq, pwm_out, running, done} !==
                {e.cnt, e.irq, e.pwm, e.run, e.dn}) begin
                miscompares++;
                $display("FAIL periodic c=%0d got cnt=%0d irq=%b pwm=%b run=%b done=%b want cnt=%0d irq=%b pwm=%b run=%b done=%b",
                         c, current_count, irq, pwm_out, running, done,
                         e.cnt, e.irq, e.pwm, e.run, e.dn);
            end
        end
    endtask

    task automatic test_pwm();
        int cnt;
        mode = 2'b11; prescale = 0; load_value = 9; compare_value = 3;
        q.push_back(mk(9, 0, 0, 0, 0));
        for (int j = 0; j <= 50; j++) begin
            cnt = 9 - (j % 10);
            q.push_back(mk(cnt, j > 0 && (j % 10 == 0), (j > 30) || (cnt >= 3), 1, 0));
        end
        q.push_back(mk(9, 0, 0, 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            load_strobe = (c == 0);
            enable = (c >= 1 && c <= 51);
            compare_value = (c >= 32) ? 12 : 3;
            @(posedge clk);
            #1;
            e = q.pop_front();
            vectors++;
            if ({current_count, irq, pwm_out, running, done} !==
                {e.cnt, e.irq, e.pwm, e.run, e.dn}) begin
                miscompares++;
                $display("FAIL pwm c=%0d got cnt=%0d irq=%b pwm=%b run=%b done=%b want cnt=%0d irq=%b pwm=%b run=%b done=%b",
                         c, current_count, irq, pwm_out, running, done,
                         e.cnt, e.irq, e.pwm, e.run, e.dn);
            end
        end
    endtask

    task automatic test_reload_in_flight();
        mode = 2'b10; prescale = 0;
        q.push_back(mk(7, 0, 0, 0, 0));
        for (int j = 0; j <= 20; j++) begin
            if (j < 8) q.push_back(mk(7 - j, 0, 0, 1, 0));
            else q.push_back(mk(3 - ((j - 8) % 4), ((j - 8) % 4) == 0, 0, 1, 0));
        end
        q.push_back(mk(3, 0, 0, 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            load_value = (c < 4) ? 7 : 3;
            load_strobe = (c == 0) || (c == 4);
            enable = (c >= 1 && c <= 21);
            @(posedge clk);
            #1;
            e = q.pop_front();
            vectors++;
            if ({current_count, irq, pwm_out, running, done} !==
                {e.cnt, e.irq, e.pwm, e.run, e.dn}) begin
                miscompares++;
                $display("FAIL reload c=%0d got cnt=%0d irq=%b pwm=%b run=%b done=%b want cnt=%0d irq=%b pwm=%b run=%b done=%b",
                         c, current_count, irq, pwm_out, running, done,
                         e.cnt, e.irq, e.pwm, e.run, e.dn);
            end
        end
    endtask

    task automatic test_abort();
        load_value = 6; compare_value = 2;
        q.push_back(mk(6, 0, 0, 0, 0));
        q.push_back(mk(6, 0, 0, 1, 0));
        q.push_back(mk(5, 0, 0, 1, 0));
        q.push_back(mk(4, 0, 0, 1, 0));
        q.push_back(mk(4, 0, 0, 0, 0));
        q.push_back(mk(6, 0, 0, 0, 0));
        q.push_back(mk(6, 0, 1, 1, 0));
        q.push_back(mk(5, 0, 1, 1, 0));
        q.push_back(mk(4, 0, 1, 1, 0));
        q.push_back(mk(4, 0, 0, 0, 0));
        q.push_back(mk(6, 0, 0, 0, 0));
        q.push_back(mk(6, 0, 0, 1, 0));
        q.push_back(mk(6, 0, 0, 1, 0));
        q.push_back(mk(6, 0, 0, 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            load_strobe = (c == 0) || (c == 5) || (c == 10);
            mode = (c < 4) ? 2'b10 : (c < 5) ? 2'b00 : (c < 10) ? 2'b11 : 2'b10;
            enable = (c >= 1 && c <= 4) || (c >= 6 && c <= 8) || (c >= 11 && c <= 12);
            prescale = (c >= 10) ? 8'd3 : 8'd0;
            @(posedge clk);
            #1;
            e = q.pop_front();
            vectors++;
            if ({current_count, irq, pwm_out, running, done} !==
                {e.cnt, e.irq, e.pwm, e.run, e.dn}) begin
                miscompares++;
                $display("FAIL abort c=%0d got cnt=%0d irq=%b pwm=%b run=%b done=%b want cnt=%0d irq=%b pwm=%b run=%b done=%b",
                         c, current_count, irq, pwm_out, running, done,
                         e.cnt, e.irq, e.pwm, e.run, e.dn);
            end
        end
    endtask

    task automatic test_async_reset();
        mode = 2'b01; prescale = 0; load_value = 5;
        q.push_back(mk(5, 0, 0, 0, 0));
        q.push_back(mk(5, 0, 0, 1, 0));
        q.push_back(mk(4, 0, 0, 1, 0));
        for (int c = 0; q.size() > 0; c++) begin
            load_strobe = (c == 0);
            enable = (c >= 1);
            @(posedge clk);
            #1;
            e = q.pop_front();
            vectors++;
            if ({current_count, irq, pwm_out, running, done} !==
                {e.cnt, e.irq, e.pwm, e.run, e.dn}) begin
                miscompares++;
                $display("FAIL pre_reset c=%0d got cnt=%0d irq=%b pwm=%b run=%b done=%b want cnt=%0d irq=%b pwm=%b run=%b done=%b",
                         c, current_count, irq, pwm_out, running, done,
                         e.cnt, e.irq, e.pwm, e.run, e.dn);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({current_count, irq, pwm_out, running, done} !== 36'd0) begin
            miscompares++;
            $display("FAIL async_reset got cnt=%0d irq=%b pwm=%b run=%b done=%b want all 0",
                     current_count, irq, pwm_out, running, done);
        end
        enable = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0));
        for (int c = 0; q.size() > 0; c++) begin
            enable = (c == 3);
            @(posedge clk);
            #1;
            e = q.pop_front();
            vectors++;
            if ({current_count, irq, pwm_out, running, done} !==
                {e.cnt, e.irq, e.pwm, e.run, e.dn}) begin
                miscompares++;
                $display("FAIL post_reset c=%0d got cnt=%0d irq=%b pwm=%b run=%b done=%b want cnt=%0d irq=%b pwm=%b run=%b done=%b",
                         c, current_count, irq, pwm_out, running, done,
                         e.cnt, e.irq, e.pwm, e.run, e.dn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic_prescale();
        test_pwm();
        test_reload_in_flight();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
